// File: rtl/channel_scan_ctrl_if.sv
`default_nettype none
// ============================================================================
// channel_scan_ctrl_if : control/status bundle of the channel scan controller
// Rev 1.0 : initial release
// ============================================================================
interface channel_scan_ctrl_if #(
  parameter int PHASE_WIDTH = 32,
  parameter int DATA_WIDTH  = 12,
  parameter int NUM_CH      = 8
);
  localparam int CH_W = $clog2(NUM_CH);

  logic                   start;
  logic                   stop;
  logic [PHASE_WIDTH-1:0] base_word;
  logic [PHASE_WIDTH-1:0] step_word;
  logic [DATA_WIDTH-1:0]  threshold;
  logic [DATA_WIDTH-1:0]  demod_in;
  logic [PHASE_WIDTH-1:0] Fre_word;
  logic [CH_W-1:0]        ch_index;
  logic [DATA_WIDTH-1:0]  peak_level;
  logic                   busy;
  logic                   locked;
  logic                   done;

  modport master (
    output start, stop, base_word, step_word, threshold, demod_in,
    input  Fre_word, ch_index, peak_level, busy, locked, done
  );

  modport slave (
    input  start, stop, base_word, step_word, threshold, demod_in,
    output Fre_word, ch_index, peak_level, busy, locked, done
  );
endinterface
`default_nettype wire

// File: rtl/channel_scan_ctrl.sv
`default_nettype none
// ============================================================================
// channel_scan_ctrl : sweeps NCO frequency words, locks on the first channel
//                     whose windowed peak level reaches the threshold
// Rev 1.0 : initial release
// ============================================================================
module channel_scan_ctrl #(
  parameter int PHASE_WIDTH   = 32,
  parameter int DATA_WIDTH    = 12,
  parameter int NUM_CH        = 8,
  parameter int SETTLE_CYCLES = 1024,
  parameter int DWELL_CYCLES  = 4096,
  parameter int LOSS_WINDOWS  = 3
) (
  input  logic               clk_in,
  input  logic               sys_rst_n,
  channel_scan_ctrl_if.slave bus
);

  localparam int CH_W    = $clog2(NUM_CH);
  localparam int MAX_CYC = (SETTLE_CYCLES > DWELL_CYCLES) ? SETTLE_CYCLES : DWELL_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam int LOSS_W  = $clog2(LOSS_WINDOWS + 1);

  localparam logic [CH_W-1:0]   CH_LAST     = CH_W'(NUM_CH - 1);
  localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  DWELL_LAST  = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [LOSS_W-1:0] LOSS_LAST   = LOSS_W'(LOSS_WINDOWS - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    TUNE    = 3'd1,
    SETTLE  = 3'd2,
    MEASURE = 3'd3,
    DECIDE  = 3'd4,
    LOCK    = 3'd5
  } state_t;

  state_t                 state;
  logic [PHASE_WIDTH-1:0] fre_reg;
  logic [CH_W-1:0]        ch_reg;
  logic [DATA_WIDTH-1:0]  peak_reg;
  logic                   busy_reg;
  logic                   locked_reg;
  logic                   done_reg;
  logic [CNT_W-1:0]       cnt;
  logic [DATA_WIDTH-1:0]  run_max;
  logic [LOSS_W-1:0]      loss;

  // Max including the current sample, so the final window cycle is counted.
  logic [DATA_WIDTH-1:0]  win_max;
  assign win_max = (bus.demod_in > run_max) ? bus.demod_in : run_max;

  always_ff @(posedge clk_in or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state      <= IDLE;
      fre_reg    <= '0;
      ch_reg     <= '0;
      peak_reg   <= '0;
      busy_reg   <= 1'b0;
      locked_reg <= 1'b0;
      done_reg   <= 1'b0;
      cnt        <= '0;
      run_max    <= '0;
      loss       <= '0;
    end else begin
      done_reg <= 1'b0;
      if (bus.stop) begin
        state      <= IDLE;
        busy_reg   <= 1'b0;
        locked_reg <= 1'b0;
        cnt        <= '0;
        run_max    <= '0;
        loss       <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (bus.start) begin
              state    <= TUNE;
              ch_reg   <= '0;
              fre_reg  <= bus.base_word;
              busy_reg <= 1'b1;
            end
          end
          TUNE: begin
            state <= SETTLE;
            cnt   <= '0;
          end
          SETTLE: begin
            if (cnt == SETTLE_LAST) begin
              state   <= MEASURE;
              cnt     <= '0;
              run_max <= '0;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          MEASURE: begin
            if (cnt == DWELL_LAST) begin
              state    <= DECIDE;
              peak_reg <= win_max;
              cnt      <= '0;
            end else begin
              run_max <= win_max;
              cnt     <= cnt + CNT_W'(1);
            end
          end
          DECIDE: begin
            if (peak_reg >= bus.threshold) begin
              state      <= LOCK;
              locked_reg <= 1'b1;
              cnt        <= '0;
              run_max    <= '0;
              loss       <= '0;
            end else if (ch_reg != CH_LAST) begin
              state   <= TUNE;
              ch_reg  <= ch_reg + CH_W'(1);
              fre_reg <= fre_reg + bus.step_word;
            end else begin
              state    <= IDLE;
              busy_reg <= 1'b0;
              done_reg <= 1'b1;
            end
          end
          LOCK: begin
            if (cnt == DWELL_LAST) begin
              peak_reg <= win_max;
              cnt      <= '0;
              run_max  <= '0;
              if (win_max >= bus.threshold) begin
                loss <= '0;
              end else if (loss == LOSS_LAST) begin
                // Lock lost: resume the sweep at the next channel, wrapping silently.
                loss       <= '0;
                locked_reg <= 1'b0;
                state      <= TUNE;
                if (ch_reg == CH_LAST) begin
                  ch_reg  <= '0;
                  fre_reg <= bus.base_word;
                end else begin
                  ch_reg  <= ch_reg + CH_W'(1);
                  fre_reg <= fre_reg + bus.step_word;
                end
              end else begin
                loss <= loss + LOSS_W'(1);
              end
            end else begin
              run_max <= win_max;
              cnt     <= cnt + CNT_W'(1);
            end
          end
          default: begin
            state      <= IDLE;
            busy_reg   <= 1'b0;
            locked_reg <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.Fre_word   = fre_reg;
  assign bus.ch_index   = ch_reg;
  assign bus.peak_level = peak_reg;
  assign bus.busy       = busy_reg;
  assign bus.locked     = locked_reg;
  assign bus.done       = done_reg;

endmodule
`default_nettype wire

// File: doc/channel_scan_ctrl.md
CHANNEL_SCAN_CTRL -- requirements
Module: channel_scan_ctrl

Interface
REQ-001 SHALL provide parameter PHASE_WIDTH, default 32, width of frequency words.
REQ-002 SHALL provide parameter DATA_WIDTH, default 12, width of demodulated level input.
REQ-003 SHALL provide parameter NUM_CH, default 8, channels per sweep (2..256).
REQ-004 SHALL provide parameter SETTLE_CYCLES, default 1024, wait after retune before measuring (>=1).
REQ-005 SHALL provide parameter DWELL_CYCLES, default 4096, measurement window length (>=1).
REQ-006 SHALL provide parameter LOSS_WINDOWS, default 3, consecutive failed windows that drop lock (>=1).
REQ-007 SHALL provide ports:
  clk_in  in  1  single system clock
  sys_rst_n  in  1  asynchronous active-low reset
  start  in  1  one-cycle pulse, begin sweep from channel 0
  stop  in  1  one-cycle pulse, abort to IDLE
  base_word  in  PHASE_WIDTH  Fre_word for channel 0
  step_word  in  PHASE_WIDTH  Fre_word increment per channel
  threshold  in  DATA_WIDTH  unsigned lock level
  demod_in  in  DATA_WIDTH  unsigned AM demodulator output
  Fre_word  out  PHASE_WIDTH  registered word to demodulator NCO
  ch_index  out  clog2(NUM_CH)  current channel
  peak_level  out  DATA_WIDTH  peak of last completed window
  busy  out  1  high in any state except IDLE
  locked  out  1  high in LOCK state
  done  out  1  one-cycle pulse: sweep ended without lock

Function
REQ-008 SHALL implement states IDLE, TUNE, SETTLE, MEASURE, DECIDE, LOCK.
REQ-009 IDLE: start=1 -> TUNE with ch_index=0, Fre_word=base_word, both registered on the transition edge.
REQ-010 TUNE SHALL last exactly 1 cycle, then SETTLE; base_word/step_word sampled only at start and channel advance.
REQ-011 SETTLE SHALL last exactly SETTLE_CYCLES cycles, then MEASURE; demod_in ignored.
REQ-012 MEASURE SHALL last exactly DWELL_CYCLES cycles, tracking unsigned max of demod_in; running max cleared on MEASURE entry.
REQ-013 On MEASURE exit, peak_level SHALL update to the window max (visible first cycle of DECIDE or next MEASURE).
REQ-014 DECIDE (1 cycle): peak_level >= threshold -> LOCK; else if ch_index < NUM_CH-1 -> TUNE with ch_index+1, Fre_word+step_word; else -> IDLE with done=1 for one cycle, Fre_word held.
REQ-015 Fre_word arithmetic SHALL be modulo 2^PHASE_WIDTH (silent wrap, no saturation).
REQ-016 LOCK: Fre_word, ch_index frozen; back-to-back DWELL_CYCLES windows run continuously, each updating peak_level.
REQ-017 LOCK: loss counter increments on each window with peak < threshold, clears on any window with peak >= threshold.
REQ-018 LOCK: loss counter reaching LOSS_WINDOWS -> counter cleared, advance to next channel (TUNE); from channel NUM_CH-1 wrap to 0 with Fre_word=base_word; no done pulse.
REQ-019 stop=1 in any state SHALL go to IDLE next cycle; Fre_word, ch_index, peak_level hold; done not asserted; priority over every other transition.
REQ-020 start while busy SHALL be ignored; start and stop in same IDLE cycle: stop wins, remain IDLE.
REQ-021 threshold=0 SHALL lock on channel 0 after first window; threshold=max SHALL lock only if demod_in hits all-ones.

Reset
REQ-022 sys_rst_n=0 SHALL asynchronously force IDLE, Fre_word=0, ch_index=0, peak_level=0, busy=0, locked=0, done=0, all counters 0.
REQ-023 Reset asserted mid-sweep or in LOCK SHALL abort identically; after release block waits for start.

Verification (NUM_CH=4, SETTLE_CYCLES=4, DWELL_CYCLES=8, LOSS_WINDOWS=2)
REQ-024 base=1000, step=100, threshold=50, demod_in=10 constant, start -> Fre_word 1000,1100,1200,1300, each channel lasting 1+4+8+1=14 cycles, done pulse 56 cycles after start, IDLE, Fre_word=1300.
REQ-025 Same, demod_in=200 only during channel 2 MEASURE -> locked=1, ch_index=2, Fre_word=1200, peak_level=200, no done.
REQ-026 Locked on channel 3, demod_in drops to 0 -> after 2 windows (16 cycles) TUNE ch_index=0, Fre_word=1000, locked=0.
REQ-027 base=32'hFFFF_FFC0, step=32'h80 -> channel 1 Fre_word=32'h0000_0040.
REQ-028 stop in SETTLE of channel 1 -> IDLE next cycle, busy=0, Fre_word=1100; sys_rst_n low in LOCK -> all outputs 0 same cycle.
